// File: rtl/id_stage_hz_if.sv
// Decode-stage bundle: IF/ID inputs, pipeline hazard/forward sources,
// WB write port, and the stall/flush/branch and ID/EX outputs.
interface id_stage_hz_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // IF/ID side and downstream freeze
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc_plus4;
  logic              id_valid;
  logic              hold_in;
  // EX / MEM instruction state for hazards and forwarding
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [4:0]        ex_dest;
  logic              mem_mem_read;
  logic              mem_reg_write;
  logic [4:0]        mem_dest;
  logic [DATA_W-1:0] alu_result_mem;
  // WB write port
  logic              reg_write_wb;
  logic [4:0]        write_reg_wb;
  logic [DATA_W-1:0] write_data_wb;
  // Control outputs (combinational)
  logic              stall_o;
  logic              flush_if;
  logic [DATA_W-1:0] branch_target;
  // ID/EX register outputs
  logic              ex_valid_o;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] imm_o;
  logic [4:0]        rs_o;
  logic [4:0]        rt_o;
  logic [4:0]        rd_o;
  logic [5:0]        opcode_o;
  logic [5:0]        funct_o;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output instruction, pc_plus4, id_valid, hold_in,
           ex_mem_read, ex_reg_write, ex_dest,
           mem_mem_read, mem_reg_write, mem_dest, alu_result_mem,
           reg_write_wb, write_reg_wb, write_data_wb,
    input  stall_o, flush_if, branch_target, ex_valid_o, rs_data_o, rt_data_o,
           imm_o, rs_o, rt_o, rd_o, opcode_o, funct_o, stall_cnt
  );

  modport slave (
    input  instruction, pc_plus4, id_valid, hold_in,
           ex_mem_read, ex_reg_write, ex_dest,
           mem_mem_read, mem_reg_write, mem_dest, alu_result_mem,
           reg_write_wb, write_reg_wb, write_data_wb,
    output stall_o, flush_if, branch_target, ex_valid_o, rs_data_o, rt_data_o,
           imm_o, rs_o, rt_o, rd_o, opcode_o, funct_o, stall_cnt
  );
endinterface

// File: rtl/id_stage_hz.sv
// MIPS decode stage: register file, MEM/WB operand forwarding, load-use and
// branch-operand hazard stall, early branch resolution with IF flush,
// registered ID/EX with bubble insertion, saturating hazard-stall counter.

// One operand's bypass mux: MEM ALU result beats WB write-through beats RF.
module id_stage_hz_fwd #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        src,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              mem_ok,
  input  logic [4:0]        mem_dest,
  input  logic [DATA_W-1:0] mem_val,
  input  logic              wb_ok,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_val,
  output logic [DATA_W-1:0] opnd
);
  // Priority select of the freshest producer of src
  always_comb begin
    opnd = rf_val;
    if (mem_ok && mem_dest == src)     opnd = mem_val;
    else if (wb_ok && wb_dest == src)  opnd = wb_val;
  end
endmodule

module id_stage_hz #(
  parameter int DATA_W  = 32,
  parameter bit HAS_BNE = 1'b1,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         rst,
  id_stage_hz_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        opcode;
    logic [5:0]        funct;
  } idex_t;

  // Field decode
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_sext;
  assign opcode   = bus.instruction[31:26];
  assign rs       = bus.instruction[25:21];
  assign rt       = bus.instruction[20:16];
  assign rd       = bus.instruction[15:11];
  assign funct    = bus.instruction[5:0];
  assign imm_sext = {{(DATA_W-16){bus.instruction[15]}}, bus.instruction[15:0]};

  // Shamt is not consumed by this stage
  logic unused_shamt;
  assign unused_shamt = ^bus.instruction[10:6];

  logic uses_rt, is_branch;
  assign uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);
  assign is_branch = (opcode == OP_BEQ) || (HAS_BNE && opcode == OP_BNE);

  // Register file; entry 0 is never written so it always reads zero
  logic [31:0][DATA_W-1:0] rf_q, rf_d;

  // Next register-file contents from the WB port
  always_comb begin
    rf_d = rf_q;
    if (bus.reg_write_wb && bus.write_reg_wb != 5'd0)
      rf_d[bus.write_reg_wb] = bus.write_data_wb;
  end

  // Register-file storage, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst) rf_q <= '0;
    else      rf_q <= rf_d;
  end

  // Operand bypass, lane 0 = rs, lane 1 = rt
  logic [1:0][4:0]        src;
  logic [1:0][DATA_W-1:0] opnd;
  logic                   mem_ok, wb_ok;
  assign src[0] = rs;
  assign src[1] = rt;
  // A MEM load has no data yet, so only ALU results forward from MEM
  assign mem_ok = bus.mem_reg_write && !bus.mem_mem_read && bus.mem_dest != 5'd0;
  assign wb_ok  = bus.reg_write_wb && bus.write_reg_wb != 5'd0;

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    id_stage_hz_fwd #(.DATA_W(DATA_W)) u_fwd (
      .src      (src[i]),
      .rf_val   (rf_q[src[i]]),
      .mem_ok   (mem_ok),
      .mem_dest (bus.mem_dest),
      .mem_val  (bus.alu_result_mem),
      .wb_ok    (wb_ok),
      .wb_dest  (bus.write_reg_wb),
      .wb_val   (bus.write_data_wb),
      .opnd     (opnd[i])
    );
  end

  // Hazards; all gated by reset so nothing stalls or flushes while in reset
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic load_use, br_ex, br_mem, hazard;
  assign ex_rs    = bus.ex_dest  == rs;
  assign ex_rt    = bus.ex_dest  == rt;
  assign mem_rs   = bus.mem_dest == rs;
  assign mem_rt   = bus.mem_dest == rt;
  assign load_use = bus.ex_mem_read && bus.ex_dest != 5'd0 && (ex_rs || (uses_rt && ex_rt));
  // Branches compare in ID, so an EX result or a MEM load is too late to bypass
  assign br_ex    = is_branch && bus.ex_reg_write && bus.ex_dest != 5'd0 && (ex_rs || ex_rt);
  assign br_mem   = is_branch && bus.mem_mem_read && bus.mem_dest != 5'd0 && (mem_rs || mem_rt);
  assign hazard   = rst && bus.id_valid && (load_use || br_ex || br_mem);

  // Early branch resolution
  logic br_cond;
  assign br_cond           = (opcode == OP_BEQ) ? (opnd[0] == opnd[1]) : (opnd[0] != opnd[1]);
  assign bus.stall_o       = rst && (hazard || bus.hold_in);
  assign bus.flush_if      = rst && bus.id_valid && is_branch && !hazard && !bus.hold_in && br_cond;
  assign bus.branch_target = bus.pc_plus4 + (imm_sext << 2);

  // ID/EX register
  idex_t idex_q, idex_d;

  // Hold freezes, hazard or empty slot inserts a bubble, otherwise capture
  always_comb begin
    idex_d = idex_q;
    if (!bus.hold_in) begin
      idex_d = '0;
      if (bus.id_valid && !hazard) begin
        idex_d.valid   = 1'b1;
        idex_d.rs_data = opnd[0];
        idex_d.rt_data = opnd[1];
        idex_d.imm     = imm_sext;
        idex_d.rs      = rs;
        idex_d.rt      = rt;
        idex_d.rd      = rd;
        idex_d.opcode  = opcode;
        idex_d.funct   = funct;
      end
    end
  end

  // ID/EX storage
  always_ff @(posedge clk) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign bus.ex_valid_o = idex_q.valid;
  assign bus.rs_data_o  = idex_q.rs_data;
  assign bus.rt_data_o  = idex_q.rt_data;
  assign bus.imm_o      = idex_q.imm;
  assign bus.rs_o       = idex_q.rs;
  assign bus.rt_o       = idex_q.rt;
  assign bus.rd_o       = idex_q.rd;
  assign bus.opcode_o   = idex_q.opcode;
  assign bus.funct_o    = idex_q.funct;

  // Hazard-stall counter; hold_in alone is not a hazard
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating increment on hazard cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Counter storage
  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: dut A (HAS_BNE=1, CNT_W=16) and
// dut B (HAS_BNE=0, CNT_W=2) share identical stimulus.
module tb_id_stage_hz;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_hz  = 0;

  id_stage_hz_if #(.DATA_W(DW), .CNT_W(16)) bus_a ();
  id_stage_hz_if #(.DATA_W(DW), .CNT_W(2))  bus_b ();

  id_stage_hz #(.DATA_W(DW), .HAS_BNE(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  id_stage_hz #(.DATA_W(DW), .HAS_BNE(1'b0), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.instruction    = bus_a.instruction;
  assign bus_b.pc_plus4       = bus_a.pc_plus4;
  assign bus_b.id_valid       = bus_a.id_valid;
  assign bus_b.hold_in        = bus_a.hold_in;
  assign bus_b.ex_mem_read    = bus_a.ex_mem_read;
  assign bus_b.ex_reg_write   = bus_a.ex_reg_write;
  assign bus_b.ex_dest        = bus_a.ex_dest;
  assign bus_b.mem_mem_read   = bus_a.mem_mem_read;
  assign bus_b.mem_reg_write  = bus_a.mem_reg_write;
  assign bus_b.mem_dest       = bus_a.mem_dest;
  assign bus_b.alu_result_mem = bus_a.alu_result_mem;
  assign bus_b.reg_write_wb   = bus_a.reg_write_wb;
  assign bus_b.write_reg_wb   = bus_a.write_reg_wb;
  assign bus_b.write_data_wb  = bus_a.write_data_wb;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.instruction    = '0;
    bus_a.pc_plus4       = '0;
    bus_a.id_valid       = 1'b0;
    bus_a.hold_in        = 1'b0;
    bus_a.ex_mem_read    = 1'b0;
    bus_a.ex_reg_write   = 1'b0;
    bus_a.ex_dest        = '0;
    bus_a.mem_mem_read   = 1'b0;
    bus_a.mem_reg_write  = 1'b0;
    bus_a.mem_dest       = '0;
    bus_a.alu_result_mem = '0;
    bus_a.reg_write_wb   = 1'b0;
    bus_a.write_reg_wb   = '0;
    bus_a.write_data_wb  = '0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [DW-1:0] d);
    bus_a.reg_write_wb  = 1'b1;
    bus_a.write_reg_wb  = r;
    bus_a.write_data_wb = d;
  endtask

  task automatic issue(input logic [31:0] ins);
    bus_a.instruction = ins;
    bus_a.id_valid    = 1'b1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt_a"}, 64'(bus_a.stall_cnt), 64'(n_hz));
    chk({tag, "_cnt_b"}, 64'(bus_b.stall_cnt), 64'((n_hz > 3) ? 3 : n_hz));
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    // Reset with random inputs: nothing stalls, flushes or counts
    for (int i = 0; i < 2; i++) begin
      bus_a.instruction    = $urandom;
      bus_a.pc_plus4       = $urandom;
      bus_a.id_valid       = 1'b1;
      bus_a.hold_in        = 1'($urandom_range(0, 1));
      bus_a.ex_mem_read    = 1'b1;
      bus_a.ex_reg_write   = 1'b1;
      bus_a.ex_dest        = 5'($urandom);
      bus_a.mem_mem_read   = 1'($urandom_range(0, 1));
      bus_a.mem_reg_write  = 1'b1;
      bus_a.mem_dest       = 5'($urandom);
      bus_a.alu_result_mem = $urandom;
      bus_a.reg_write_wb   = 1'b1;
      bus_a.write_reg_wb   = 5'd5;
      bus_a.write_data_wb  = $urandom | 32'h1;
      #1;
      chk("rst_stall_a", 64'(bus_a.stall_o), 64'd0);
      chk("rst_flush_a", 64'(bus_a.flush_if), 64'd0);
      chk("rst_stall_b", 64'(bus_b.stall_o), 64'd0);
      tick();
    end
    chk("rst_valid", 64'(bus_a.ex_valid_o), 64'd0);
    chk("rst_rs", 64'(bus_a.rs_data_o), 64'd0);
    chk("rst_rt", 64'(bus_a.rt_data_o), 64'd0);
    chk("rst_imm", 64'(bus_a.imm_o), 64'd0);
    chk("rst_op", 64'(bus_a.opcode_o), 64'd0);
    chk("rst_rd", 64'(bus_a.rd_o), 64'd0);
    chk_cnt("rst");

    // Leave reset, read r5 (written only during reset)
    rst = 1'b1;
    idle();
    issue(rtype(5'd5, 5'd5, 5'd1, 6'h20));
    #1 chk("r5_stall", 64'(bus_a.stall_o), 64'd0);
    tick();
    chk("r5_rs", 64'(bus_a.rs_data_o), 64'd0);
    chk("r5_valid", 64'(bus_a.ex_valid_o), 64'd1);
    chk("r5_rd", 64'(bus_a.rd_o), 64'd1);
    chk("r5_funct", 64'(bus_a.funct_o), 64'h20);

    // MEM ALU beats WB write-through
    idle();
    wb(5'd3, 32'h11);
    bus_a.mem_reg_write = 1'b1; bus_a.mem_dest = 5'd3; bus_a.alu_result_mem = 32'h22;
    issue(rtype(5'd3, 5'd3, 5'd4, 6'h20));
    tick();
    chk("fwd_mem_rs", 64'(bus_a.rs_data_o), 64'h22);
    chk("fwd_mem_rt", 64'(bus_a.rt_data_o), 64'h22);
    chk("fwd_mem_rd", 64'(bus_a.rd_o), 64'd4);
    // WB write-through with MEM inactive
    bus_a.mem_reg_write = 1'b0;
    tick();
    chk("fwd_wb_rs", 64'(bus_a.rs_data_o), 64'h11);
    chk("fwd_wb_rt", 64'(bus_a.rt_data_o), 64'h11);
    // r3 from the register file, r1 via WB write-through
    idle();
    wb(5'd1, 32'h7);
    issue(rtype(5'd3, 5'd1, 5'd6, 6'h20));
    tick();
    chk("rf_rs", 64'(bus_a.rs_data_o), 64'h11);
    chk("wb_rt", 64'(bus_a.rt_data_o), 64'h7);
    // Empty slot -> bubble
    idle();
    wb(5'd2, 32'h7);
    tick();
    chk("bub_valid", 64'(bus_a.ex_valid_o), 64'd0);
    chk("bub_rs", 64'(bus_a.rs_data_o), 64'd0);
    // Write to r0 is ignored and never bypassed
    idle();
    wb(5'd0, 32'h55);
    issue(rtype(5'd0, 5'd2, 5'd7, 6'h20));
    tick();
    chk("r0_rs", 64'(bus_a.rs_data_o), 64'd0);
    chk("r0_rt", 64'(bus_a.rt_data_o), 64'h7);
    idle();
    issue(rtype(5'd0, 5'd0, 5'd7, 6'h20));
    tick();
    chk("r0_read", 64'(bus_a.rs_data_o), 64'd0);
    // MEM load result is not forwarded, and does not stall a non-branch
    idle();
    bus_a.mem_reg_write = 1'b1; bus_a.mem_mem_read = 1'b1;
    bus_a.mem_dest = 5'd3; bus_a.alu_result_mem = 32'h99;
    issue(rtype(5'd3, 5'd0, 5'd8, 6'h20));
    #1 chk("memld_stall", 64'(bus_a.stall_o), 64'd0);
    tick();
    chk("memld_rs", 64'(bus_a.rs_data_o), 64'h11);

    // Load-use on rs
    idle();
    bus_a.ex_mem_read = 1'b1; bus_a.ex_reg_write = 1'b1; bus_a.ex_dest = 5'd2;
    issue(rtype(5'd2, 5'd0, 5'd1, 6'h20));
    #1 chk("lu_stall", 64'(bus_a.stall_o), 64'd1);
    n_hz++;
    tick();
    chk("lu_valid", 64'(bus_a.ex_valid_o), 64'd0);
    chk_cnt("lu");
    bus_a.ex_mem_read = 1'b0; bus_a.ex_reg_write = 1'b0;
    #1 chk("lu_clr_stall", 64'(bus_a.stall_o), 64'd0);
    tick();
    chk("lu_clr_valid", 64'(bus_a.ex_valid_o), 64'd1);
    chk("lu_clr_rs", 64'(bus_a.rs_data_o), 64'h7);
    chk("lu_clr_rd", 64'(bus_a.rd_o), 64'd1);
    // addi does not read rt: no hazard on rt match
    bus_a.ex_mem_read = 1'b1; bus_a.ex_dest = 5'd2;
    issue(itype(6'h08, 5'd0, 5'd2, 16'd5));
    #1 chk("addi_stall", 64'(bus_a.stall_o), 64'd0);
    tick();
    chk("addi_imm", 64'(bus_a.imm_o), 64'd5);
    chk("addi_rt", 64'(bus_a.rt_o), 64'd2);
    // sw reads rt: hazard
    issue(itype(6'h2B, 5'd0, 5'd2, 16'd0));
    #1 chk("sw_stall", 64'(bus_a.stall_o), 64'd1);
    n_hz++;
    tick();
    chk("sw_valid", 64'(bus_a.ex_valid_o), 64'd0);
    chk_cnt("sw");

    // Branches: r1 = r2 = 7
    idle();
    bus_a.pc_plus4 = 32'h100;
    issue(itype(6'h04, 5'd1, 5'd2, 16'd4));
    #1;
    chk("beq_flush_a", 64'(bus_a.flush_if), 64'd1);
    chk("beq_flush_b", 64'(bus_b.flush_if), 64'd1);
    chk("beq_tgt", 64'(bus_a.branch_target), 64'h110);
    chk("beq_stall", 64'(bus_a.stall_o), 64'd0);
    tick();
    chk("beq_valid", 64'(bus_a.ex_valid_o), 64'd1);
    chk("beq_op", 64'(bus_a.opcode_o), 64'h04);
    issue(itype(6'h05, 5'd1, 5'd2, 16'd4));
    #1;
    chk("bne_eq_a", 64'(bus_a.flush_if), 64'd0);
    chk("bne_eq_b", 64'(bus_b.flush_if), 64'd0);
    tick();
    issue(itype(6'h05, 5'd1, 5'd0, 16'd4));
    #1;
    chk("bne_ne_a", 64'(bus_a.flush_if), 64'd1);
    chk("bne_ne_b", 64'(bus_b.flush_if), 64'd0);
    tick();
    issue(itype(6'h04, 5'd1, 5'd2, 16'hFFFF));
    #1 chk("tgt_neg", 64'(bus_a.branch_target), 64'hFC);
    tick();
    chk("imm_neg", 64'(bus_a.imm_o), 64'hFFFF_FFFF);
    bus_a.pc_plus4 = 32'hFFFF_FFFC;
    issue(itype(6'h04, 5'd1, 5'd2, 16'd2));
    #1 chk("tgt_wrap", 64'(bus_a.branch_target), 64'h4);
    bus_a.id_valid = 1'b0;
    #1 chk("beq_novalid", 64'(bus_a.flush_if), 64'd0);
    tick();

    // Branch on EX result: stall, no flush despite equal operands
    idle();
    bus_a.ex_reg_write = 1'b1; bus_a.ex_dest = 5'd1;
    issue(itype(6'h04, 5'd1, 5'd1, 16'd0));
    #1;
    chk("brex_stall", 64'(bus_a.stall_o), 64'd1);
    chk("brex_flush", 64'(bus_a.flush_if), 64'd0);
    n_hz++;
    tick();
    chk("brex_valid", 64'(bus_a.ex_valid_o), 64'd0);
    chk_cnt("brex");
    issue(rtype(5'd1, 5'd0, 5'd9, 6'h20));
    #1 chk("addex_stall", 64'(bus_a.stall_o), 64'd0);
    tick();
    // Branch on MEM load
    idle();
    bus_a.mem_mem_read = 1'b1; bus_a.mem_reg_write = 1'b1; bus_a.mem_dest = 5'd2;
    issue(itype(6'h04, 5'd2, 5'd2, 16'd0));
    #1;
    chk("brmem_stall", 64'(bus_a.stall_o), 64'd1);
    chk("brmem_flush", 64'(bus_a.flush_if), 64'd0);
    n_hz++;
    tick();
    chk_cnt("brmem");
    // MEM ALU forwarded into the compare: r1 -> 0 equals r0
    idle();
    bus_a.mem_reg_write = 1'b1; bus_a.mem_dest = 5'd1; bus_a.alu_result_mem = '0;
    issue(itype(6'h04, 5'd1, 5'd0, 16'd0));
    #1 chk("brfwd_flush", 64'(bus_a.flush_if), 64'd1);
    tick();
    chk("brfwd_rs", 64'(bus_a.rs_data_o), 64'd0);

    // hold_in freezes ID/EX and suppresses flush without counting
    idle();
    issue(rtype(5'd1, 5'd2, 5'd5, 6'h20));
    tick();
    chk("pre_hold_rs", 64'(bus_a.rs_data_o), 64'h7);
    bus_a.hold_in = 1'b1;
    bus_a.pc_plus4 = 32'h100;
    issue(itype(6'h04, 5'd1, 5'd2, 16'd4));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", 64'(bus_a.stall_o), 64'd1);
      chk("hold_flush", 64'(bus_a.flush_if), 64'd0);
      tick();
      chk("hold_valid", 64'(bus_a.ex_valid_o), 64'd1);
      chk("hold_rs", 64'(bus_a.rs_data_o), 64'h7);
      chk("hold_rd", 64'(bus_a.rd_o), 64'd5);
      chk("hold_op", 64'(bus_a.opcode_o), 64'd0);
      chk_cnt("hold");
    end
    bus_a.hold_in = 1'b0;
    tick();
    chk("unhold_op", 64'(bus_a.opcode_o), 64'h04);

    // Five more hazard cycles: B saturates at 3
    idle();
    bus_a.ex_mem_read = 1'b1; bus_a.ex_dest = 5'd3;
    issue(rtype(5'd3, 5'd0, 5'd1, 6'h20));
    for (int i = 0; i < 5; i++) begin
      n_hz++;
      tick();
    end
    chk_cnt("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
